qtable_banked: RTL and testbench

Parametrised Q-value store that replaces the single-word Q-table memory in the learning datapath. Holds one DATA_WIDTH Q-value per (state, action) pair, banked by action, so one read returns every action's Q-value for a state in one cycle, which the max/argmax stage needs. Accepts one single-action write per cycle from the update stage. Includes a hardware clear sequencer that zeroes the whole table after reset or on request, instead of relying on simulation-only initialisation.

---
 rtl/qtable_banked_if.sv | 30 +++
 rtl/qtable_banked.sv | 90 +++++++++
 tb/tb_qtable_banked.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/qtable_banked_if.sv
// Request/response bundle for the banked Q-value store: clear, read and write requests in,
// ready/valid/all-action read data out.
interface qtable_banked_if #(
    parameter int unsigned STATE_WIDTH  = 16,
    parameter int unsigned ACTION_WIDTH = 2,
    parameter int unsigned DATA_WIDTH   = 32
);
    localparam int unsigned NUM_ACTIONS = 2 ** ACTION_WIDTH;

    logic                              i_clear;
    logic                              o_ready;
    logic                              i_read_en;
    logic [STATE_WIDTH-1:0]            i_state_r;
    logic                              i_write_en;
    logic [STATE_WIDTH-1:0]            i_state_w;
    logic [ACTION_WIDTH-1:0]           i_action_w;
    logic [DATA_WIDTH-1:0]             i_data;
    logic                              o_valid;
    logic [NUM_ACTIONS*DATA_WIDTH-1:0] o_data;

    modport master (
        output i_clear, i_read_en, i_state_r, i_write_en, i_state_w, i_action_w, i_data,
        input  o_ready, o_valid, o_data
    );

    modport slave (
        input  i_clear, i_read_en, i_state_r, i_write_en, i_state_w, i_action_w, i_data,
        output o_ready, o_valid, o_data
    );
endinterface

// File: rtl/qtable_banked.sv
// Q-value table banked by action: one all-action read and one single-action write per cycle,
// with a hardware clear sweep. Optional write-first bypass: define QTABLE_BYPASS_EN.
module qtable_banked #(
    parameter int unsigned STATE_WIDTH  = 16,
    parameter int unsigned ACTION_WIDTH = 2,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    qtable_banked_if.slave bus
);
    localparam int unsigned DEPTH       = 2 ** STATE_WIDTH;
    localparam int unsigned NUM_ACTIONS = 2 ** ACTION_WIDTH;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                            state;
    logic [STATE_WIDTH-1:0]            cnt;
    logic                              sweep_c;
    logic                              read_c;
    logic                              write_c;
    logic [NUM_ACTIONS*DATA_WIDTH-1:0] rd_lanes_c;

    assign sweep_c = (state == CLEAR) && !i_rst;
    assign read_c  = (state == IDLE) && !i_rst && bus.i_read_en;
    assign write_c = (state == IDLE) && !i_rst && bus.i_write_en;

    // One bank per action; the sweep zeroes every bank at the same address.
    for (genvar a = 0; a < NUM_ACTIONS; a++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic                  wr_hit_c;

        assign wr_hit_c = write_c && (bus.i_action_w == ACTION_WIDTH'(a));

        always_ff @(posedge i_clk) begin
            if (sweep_c) begin
                mem[cnt] <= '0;
            end else if (wr_hit_c) begin
                mem[bus.i_state_w] <= bus.i_data;
            end
        end

`ifdef QTABLE_BYPASS_EN
        // Write-first: a same-state write in the read cycle overrides this lane's stored value.
        assign rd_lanes_c[a*DATA_WIDTH +: DATA_WIDTH] =
            (wr_hit_c && (bus.i_state_w == bus.i_state_r)) ? bus.i_data : mem[bus.i_state_r];
`else
        assign rd_lanes_c[a*DATA_WIDTH +: DATA_WIDTH] = mem[bus.i_state_r];
`endif
    end

    // Control FSM: sweep the table after reset or on request, otherwise serve reads.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= CLEAR;
            cnt         <= '0;
            bus.o_ready <= 1'b0;
            bus.o_valid <= 1'b0;
            bus.o_data  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    bus.o_valid <= 1'b0;
                    cnt         <= cnt + STATE_WIDTH'(1);
                    if (cnt == STATE_WIDTH'(DEPTH - 1)) begin
                        state       <= IDLE;
                        bus.o_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    bus.o_valid <= read_c;
                    if (read_c) begin
                        bus.o_data <= rd_lanes_c;
                    end
                    if (bus.i_clear) begin
                        state       <= CLEAR;
                        cnt         <= '0;
                        bus.o_ready <= 1'b0;
                    end
                end
                default: begin
                    state       <= CLEAR;
                    cnt         <= '0;
                    bus.o_ready <= 1'b0;
                    bus.o_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qtable_banked.sv
// Directed bench for qtable_banked: vector table for read/write behaviour plus hand-written
// sequences for the clear sweep, reset during a sweep, and streaming reads.
module tb_qtable_banked;
    localparam int unsigned SW = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned NV = 14;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    qtable_banked_if #(.STATE_WIDTH(SW), .ACTION_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    qtable_banked #(.STATE_WIDTH(SW), .ACTION_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic [3:0]   sr;
        logic         wr;
        logic [3:0]   sw;
        logic [1:0]   aw;
        logic [31:0]  d;
        logic         ev;
        logic [127:0] ed;
    } vec_t;

    vec_t        vt [NV];
    logic [31:0] model [16][4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [3:0] sr, input logic wr,
                         input logic [3:0] sw, input logic [1:0] aw, input logic [31:0] d,
                         input logic clr);
        bus.i_read_en  = rd;
        bus.i_state_r  = sr;
        bus.i_write_en = wr;
        bus.i_state_w  = sw;
        bus.i_action_w = aw;
        bus.i_data     = d;
        bus.i_clear    = clr;
    endtask

    function automatic logic [127:0] pack(input int s);
        logic [127:0] r;
        for (int a = 0; a < 4; a++) r[a*32 +: 32] = model[s][a];
        return r;
    endfunction

    // Expected o_ready over the 16 cycles following a reset release or a clear request.
    task automatic check_sweep(input string name);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check(name, 128'(bus.o_ready), 128'(i == 16));
        end
    endtask

    initial begin
        logic [127:0] l5a, l5b, l7a, l7b, l7c, same5, same7;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);

        l5a = 128'h00000000_3F800000_00000000_00000000;
        l5b = 128'h00000000_40000000_00000000_00000000;
        l7a = 128'h00000000_00000003_00000002_00000001;
        l7b = 128'h00000004_00000003_00000002_00000001;
        l7c = 128'h00000004_00000003_00000002_000000CC;
`ifdef QTABLE_BYPASS_EN
        same5 = l5b;
        same7 = l7b;
`else
        same5 = l5a;
        same7 = l7a;
`endif
        //       rd sr   wr sw   aw  data            ev  expected o_data
        vt[0]  = '{0, 0, 1, 5, 2, 32'h3F800000, 0, 128'h0};
        vt[1]  = '{1, 5, 0, 0, 0, 32'h0,        1, l5a};
        vt[2]  = '{1, 5, 1, 5, 2, 32'h40000000, 1, same5};
        vt[3]  = '{0, 0, 0, 0, 0, 32'h0,        0, same5};
        vt[4]  = '{1, 5, 0, 0, 0, 32'h0,        1, l5b};
        vt[5]  = '{1, 5, 1, 7, 0, 32'h1,        1, l5b};
        vt[6]  = '{0, 0, 1, 7, 1, 32'h2,        0, l5b};
        vt[7]  = '{0, 0, 1, 7, 2, 32'h3,        0, l5b};
        vt[8]  = '{1, 7, 1, 7, 3, 32'h4,        1, same7};
        vt[9]  = '{1, 7, 0, 0, 0, 32'h0,        1, l7b};
        vt[10] = '{0, 0, 1, 3, 1, 32'hAA,       0, l7b};
        vt[11] = '{0, 0, 1, 3, 1, 32'hBB,       0, l7b};
        vt[12] = '{1, 3, 1, 7, 0, 32'hCC,       1, 128'h00000000_00000000_000000BB_00000000};
        vt[13] = '{1, 7, 0, 0, 0, 32'h0,        1, l7c};

        // Reset state, then the power-up sweep.
        repeat (3) tick();
        check("rst_ready", 128'(bus.o_ready), 128'h0);
        check("rst_valid", 128'(bus.o_valid), 128'h0);
        check("rst_data", bus.o_data, 128'h0);
        rst = 1'b0;
        check_sweep("init_ready");

        // Every state reads zero, valid one cycle after each request.
        for (int s = 0; s < 16; s++) begin
            drive(1, 4'(s), 0, 0, 0, 0, 0);
            tick();
            check("init_valid", 128'(bus.o_valid), 128'h1);
            check("init_data", bus.o_data, 128'h0);
        end

        for (int i = 0; i < int'(NV); i++) begin
            drive(vt[i].rd, vt[i].sr, vt[i].wr, vt[i].sw, vt[i].aw, vt[i].d, 0);
            tick();
            check($sformatf("vec%0d_valid", i), 128'(bus.o_valid), 128'(vt[i].ev));
            check($sformatf("vec%0d_data", i), bus.o_data, vt[i].ed);
        end

        // Clear request with a same-cycle read; requests during the sweep are dropped.
        drive(1, 7, 0, 0, 0, 0, 1);
        tick();
        check("clr_ready0", 128'(bus.o_ready), 128'h0);
        check("clr_rd_valid", 128'(bus.o_valid), 128'h1);
        check("clr_rd_data", bus.o_data, l7c);
        drive(1, 5, 1, 9, 0, 32'hDEAD, 1);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("clr_ready", 128'(bus.o_ready), 128'(i == 16));
            check("clr_valid", 128'(bus.o_valid), 128'h0);
            check("clr_hold", bus.o_data, l7c);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        foreach (vt[i]) begin end
        for (int k = 0; k < 3; k++) begin
            drive(1, (k == 0) ? 4'd7 : (k == 1) ? 4'd9 : 4'd5, 0, 0, 0, 0, 0);
            tick();
            check("post_clr_valid", 128'(bus.o_valid), 128'h1);
            check("post_clr_data", bus.o_data, 128'h0);
        end

        // Reset 8 cycles into a sweep restarts it from address 0.
        drive(0, 0, 1, 2, 3, 32'h55, 0);
        tick();
        drive(1, 2, 0, 0, 0, 0, 1);
        tick();
        check("rs_rd_data", bus.o_data, 128'h00000055_00000000_00000000_00000000);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (8) tick();
        check("rs_mid_ready", 128'(bus.o_ready), 128'h0);
        rst = 1'b1;
        repeat (2) tick();
        check("rs_ready", 128'(bus.o_ready), 128'h0);
        check("rs_valid", 128'(bus.o_valid), 128'h0);
        check("rs_data", bus.o_data, 128'h0);
        rst = 1'b0;
        check_sweep("rs_sweep_ready");
        drive(1, 2, 0, 0, 0, 0, 0);
        tick();
        check("rs_cleared", bus.o_data, 128'h0);

        // Streaming reads of prefilled states while writing state 12.
        for (int s = 0; s < 16; s++) for (int a = 0; a < 4; a++) model[s][a] = 32'h0;
        for (int s = 0; s < 8; s++) begin
            drive(0, 0, 1, 4'(s), 2'(s % 4), 32'h1000 + 32'(s), 0);
            model[s][s % 4] = 32'h1000 + 32'(s);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1, 4'(7 - i), 1, 12, 2'(i % 4), 32'h2000 + 32'(i), 0);
            tick();
            check("stream_valid", 128'(bus.o_valid), 128'h1);
            check("stream_data", bus.o_data, pack(7 - i));
            model[12][i % 4] = 32'h2000 + 32'(i);
        end
        drive(1, 12, 0, 0, 0, 0, 0);
        tick();
        check("stream_s12", bus.o_data, pack(12));
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("stream_end_valid", 128'(bus.o_valid), 128'h0);
        check("stream_end_hold", bus.o_data, pack(12));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
